dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 171 +++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-accumulate: optional pre-adder, M_STAGES multiplier registers,
// post-adder with sticky overflow. Define DSP_MAC_PIPE_SAT_EN to saturate instead of wrap.
module dsp_mac_pipe #(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter int M_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  RSTA,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [B_W-1:0] d,
  input  logic signed [P_W-1:0] c,
  input  logic [3:0]            op,
  input  logic                  clr_ovf,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p,
  output logic                  ovf
);

  localparam int PRE_W = B_W + 1;
  localparam int PR_W  = A_W + B_W + 1;
  localparam int SUM_W = P_W + 1;
  localparam int LAST  = M_STAGES - 1;

  // stage 1: input capture
  logic signed [A_W-1:0]   a1_q, a1_d;
  logic signed [B_W-1:0]   b1_q, b1_d, d1_q, d1_d;
  logic signed [P_W-1:0]   c1_q, c1_d;
  logic [3:0]              op1_q, op1_d;
  logic                    v1_q, v1_d;

  // stage 2: pre-adder result
  logic signed [A_W-1:0]   a2_q, a2_d;
  logic signed [PRE_W-1:0] pre2_q, pre2_d;
  logic signed [P_W-1:0]   c2_q, c2_d;
  logic [3:0]              op2_q, op2_d;
  logic                    v2_q, v2_d;

  // multiplier stages, each carrying its beat's c/op/valid alongside the product
  logic signed [PR_W-1:0]  mul_q [M_STAGES];
  logic signed [PR_W-1:0]  mul_d [M_STAGES];
  logic signed [P_W-1:0]   mc_q  [M_STAGES];
  logic signed [P_W-1:0]   mc_d  [M_STAGES];
  logic [3:0]              mop_q [M_STAGES];
  logic [3:0]              mop_d [M_STAGES];
  logic                    mv_q  [M_STAGES];
  logic                    mv_d  [M_STAGES];

  // final stage
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;

  logic signed [P_W-1:0]   prod_ext;
  logic signed [P_W-1:0]   z;
  logic signed [SUM_W-1:0] sum;
  logic                    sum_ovf;
  logic signed [P_W-1:0]   result;
  logic                    fire;

  always_comb begin
    a1_d  = a;
    b1_d  = b;
    d1_d  = d;
    c1_d  = c;
    op1_d = op;
    v1_d  = in_valid;

    a2_d  = a1_q;
    c2_d  = c1_q;
    op2_d = op1_q;
    v2_d  = v1_q;
    if (!op1_q[0])
      pre2_d = PRE_W'(b1_q);
    else if (op1_q[1])
      pre2_d = PRE_W'(d1_q) - PRE_W'(b1_q);
    else
      pre2_d = PRE_W'(d1_q) + PRE_W'(b1_q);

    mul_d[0] = PR_W'(a2_q) * PR_W'(pre2_q);
    mc_d[0]  = c2_q;
    mop_d[0] = op2_q;
    mv_d[0]  = v2_q;
    for (int i = 1; i < M_STAGES; i++) begin
      mul_d[i] = mul_q[i-1];
      mc_d[i]  = mc_q[i-1];
      mop_d[i] = mop_q[i-1];
      mv_d[i]  = mv_q[i-1];
    end

    prod_ext = P_W'(mul_q[LAST]);
    z        = mop_q[LAST][2] ? p_q : mc_q[LAST];
    if (mop_q[LAST][3])
      sum = SUM_W'(z) - SUM_W'(prod_ext);
    else
      sum = SUM_W'(z) + SUM_W'(prod_ext);
    // one extra bit of headroom: top two bits disagree exactly when P_W bits overflow
    sum_ovf = sum[P_W] ^ sum[P_W-1];
`ifdef DSP_MAC_PIPE_SAT_EN
    if (sum_ovf)
      result = sum[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    else
      result = sum[P_W-1:0];
`else
    result = sum[P_W-1:0];
`endif

    fire        = ce & mv_q[LAST];
    p_d         = fire ? result : p_q;
    out_valid_d = ce ? mv_q[LAST] : out_valid_q;
    ovf_d       = (ovf_q & ~clr_ovf) | (fire & sum_ovf);
  end

  always_ff @(posedge clk or posedge RSTA) begin
    if (RSTA) begin
      a1_q        <= '0;
      b1_q        <= '0;
      d1_q        <= '0;
      c1_q        <= '0;
      op1_q       <= '0;
      v1_q        <= 1'b0;
      a2_q        <= '0;
      pre2_q      <= '0;
      c2_q        <= '0;
      op2_q       <= '0;
      v2_q        <= 1'b0;
      for (int i = 0; i < M_STAGES; i++) begin
        mul_q[i] <= '0;
        mc_q[i]  <= '0;
        mop_q[i] <= '0;
        mv_q[i]  <= 1'b0;
      end
      p_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (ce) begin
        a1_q   <= a1_d;
        b1_q   <= b1_d;
        d1_q   <= d1_d;
        c1_q   <= c1_d;
        op1_q  <= op1_d;
        v1_q   <= v1_d;
        a2_q   <= a2_d;
        pre2_q <= pre2_d;
        c2_q   <= c2_d;
        op2_q  <= op2_d;
        v2_q   <= v2_d;
        for (int i = 0; i < M_STAGES; i++) begin
          mul_q[i] <= mul_d[i];
          mc_q[i]  <= mc_d[i];
          mop_q[i] <= mop_d[i];
          mv_q[i]  <= mv_d[i];
        end
      end
      // clr_ovf acts regardless of ce; p/out_valid already fold ce into their _d
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Randomized bench for dsp_mac_pipe: a queue-based beat model predicts p/out_valid/ovf
// every cycle, plus directed beats with hand-computed results.
module tb_dsp_mac_pipe;
  localparam int     LAT  = 4;
  localparam longint MAXV = 64'sd140737488355327;
  localparam longint MINV = -64'sd140737488355328;
  localparam longint MODV = 64'sd281474976710656;

  logic               clk;
  logic               rst_a;
  logic               ce;
  logic               in_valid;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c;
  logic [3:0]         op;
  logic               clr_ovf;
  logic               out_valid;
  logic signed [47:0] p;
  logic               ovf;

  int n_vec  = 0;
  int n_fail = 0;

  dsp_mac_pipe dut (
    .clk(clk), .RSTA(rst_a), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .op(op), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .p(p), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    longint   a, b, d, c;
    logic [3:0] op;
    int       rem;
  } beat_t;

  beat_t  mq[$];
  beat_t  bt;
  longint m_p   = 0;
  logic   m_ov  = 1'b0;
  logic   m_ovf = 1'b0;
  logic   nf;
  longint opnd, prod, zz, s;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      mq.delete();
      m_p   = 0;
      m_ov  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      nf = m_ovf & ~clr_ovf;
      if (ce) begin
        m_ov = 1'b0;
        foreach (mq[i]) mq[i].rem--;
        if (mq.size() > 0 && mq[0].rem == 0) begin
          bt   = mq.pop_front();
          opnd = !bt.op[0] ? bt.b : (bt.op[1] ? bt.d - bt.b : bt.d + bt.b);
          prod = bt.a * opnd;
          zz   = bt.op[2] ? m_p : bt.c;
          s    = bt.op[3] ? zz - prod : zz + prod;
          if (s > MAXV || s < MINV) begin
            nf = 1'b1;
`ifdef DSP_MAC_PIPE_SAT_EN
            m_p = (s > MAXV) ? MAXV : MINV;
`else
            m_p = (s > MAXV) ? s - MODV : s + MODV;
`endif
          end else begin
            m_p = s;
          end
          m_ov = 1'b1;
        end
        if (in_valid) begin
          bt.a = longint'(a); bt.b = longint'(b); bt.d = longint'(d);
          bt.c = longint'(c); bt.op = op; bt.rem = LAT - 1;
          mq.push_back(bt);
        end
      end
      m_ovf = nf;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_a) begin
      chk("out_valid", longint'(out_valid), longint'(m_ov));
      chk("p", longint'(p), m_p);
      chk("ovf", longint'(ovf), longint'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input int av, input int bv, input int dv, input longint cv, input logic [3:0] opv);
    @(negedge clk);
    a = 18'(av); b = 18'(bv); d = 18'(dv); c = 48'(cv); op = opv;
    ce = 1'b1; in_valid = 1'b1;
  endtask

  task automatic wait_out(input string nm, input longint exp_p, input int exp_lat);
    int cnt  = 0;
    bit seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
      if (out_valid) seen = 1'b1;
    end
    chk({nm, "_seen"}, longint'(seen), 1);
    if (seen) begin
      chk({nm, "_lat"}, cnt, exp_lat);
      chk({nm, "_p"}, longint'(p), exp_p);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_a = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint cv;
    rst_a = 1'b1; ce = 1'b0; in_valid = 1'b0; clr_ovf = 1'b0;
    a = '0; b = '0; d = '0; c = '0; op = '0;
    repeat (3) @(negedge clk);
    chk("rst_p", longint'(p), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    rst_a = 1'b0; ce = 1'b1;

    // 3*5 + 10
    beat(3, 5, 0, 10, 4'b0000);
    wait_out("basic", 25, LAT);
    chk("basic_ovf", longint'(ovf), 0);

    // two accumulating beats right after reset: 0+14, then 14-4
    pulse_reset();
    beat(2, 7, 0, 0, 4'b0100);
    beat(-1, 4, 0, 0, 4'b0100);
    wait_out("acc1", 14, LAT - 1);
    @(negedge clk);
    chk("acc2_valid", longint'(out_valid), 1);
    chk("acc2_p", longint'(p), 10);

    // pre-subtract 4*(10-3)=28, then 100 - 4*(10+3) = 48
    beat(4, 3, 10, 0, 4'b0011);
    wait_out("presub", 28, LAT);
    beat(4, 3, 10, 100, 4'b1001);
    wait_out("postsub", 48, LAT);

    // three ce=0 cycles mid-flight stretch latency by three; p holds meanwhile
    beat(1, 1, 0, 5, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0; ce = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("hold_p", longint'(p), 48);
      chk("hold_valid", longint'(out_valid), 0);
    end
    @(negedge clk);
    ce = 1'b1;
    wait_out("hold", 6, LAT - 1);
    ce = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_out_p", longint'(p), 6);
    end
    ce = 1'b1;
    @(negedge clk);
    chk("hold_release", longint'(out_valid), 0);

    // positive overflow
    beat(1, 1, 0, MAXV, 4'b0000);
`ifdef DSP_MAC_PIPE_SAT_EN
    wait_out("ovf", MAXV, LAT);
`else
    wait_out("ovf", MINV, LAT);
`endif
    chk("ovf_set", longint'(ovf), 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", longint'(ovf), 0);

    // clear and new overflow on the same edge: overflow wins
    beat(1, 1, 0, MAXV, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_race_valid", longint'(out_valid), 1);
    chk("ovf_race", longint'(ovf), 1);

    // async reset with three beats in flight
    beat(3, 3, 0, 1, 4'b0000);
    beat(3, 3, 0, 2, 4'b0000);
    beat(3, 3, 0, 3, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_a = 1'b1;
    #1;
    chk("arst_p", longint'(p), 0);
    chk("arst_valid", longint'(out_valid), 0);
    chk("arst_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("arst_no_out", longint'(out_valid), 0);
    end

    // randomized traffic, model compare runs every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      ce       = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 6);
      clr_ovf  = ($urandom_range(0, 19) == 0);
      a  = 18'($urandom);
      b  = 18'($urandom);
      d  = 18'($urandom);
      op = 4'($urandom);
      case ($urandom_range(0, 3))
        0: cv = longint'($urandom_range(0, 2000)) - 1000;
        1: cv = MAXV - longint'($urandom_range(0, 1 << 20));
        2: cv = MINV + longint'($urandom_range(0, 1 << 20));
        default: cv = longint'({$urandom, $urandom});
      endcase
      c = 48'(cv);
    end
    @(negedge clk);
    in_valid = 1'b0; ce = 1'b1;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
